// File: rtl/gf2m_ks_mult_seq_if.sv
// Operand/result handshake bundle for the digit-serial GF(2)[x] multiplier.
interface gf2m_ks_mult_seq_if #(
  parameter int unsigned M = 233
) ();

  logic           in_valid;
  logic           in_ready;
  logic [M-1:0]   a;
  logic [M-1:0]   b;
  logic           mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*M-2:0] y;

  // Producer/consumer side that drives operands and accepts results.
  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, y
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, y
  );

endinterface

// File: rtl/gf2m_ks_mult_seq.sv
// Digit-serial carry-less multiplier over GF(2)[x], MSB-first digits of b,
// with optional same-cycle reduction modulo POLY (mode = 1).
module gf2m_ks_mult_seq #(
  parameter int unsigned M    = 233,
  parameter int unsigned D    = 16,
  parameter logic [M:0]  POLY = {1'b1, 158'd0, 1'b1, 73'd0, 1'b1}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gf2m_ks_mult_seq_if.slave    bus
);

  localparam int unsigned NDIG = (M + D - 1) / D;
  localparam int unsigned BW   = NDIG * D;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned AW   = 2 * M - 1;
  localparam int unsigned PW   = M + D - 1;
  localparam int unsigned TW   = (AW > M + D) ? AW : M + D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [M-1:0]    a_q;
  logic [BW-1:0]   b_q;
  logic            mode_q;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_d;
  logic [AW-1:0]   y_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [D-1:0]    digit;
  logic [PW-1:0]   pp;
  logic [TW-1:0]   t;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;

  // One digit step: shift accumulator, add D x M partial product, optionally reduce.
  always_comb begin
    digit = D'(b_q >> (D * cnt_q));
    pp    = '0;
    for (int j = 0; j < int'(D); j++) begin
      if (digit[j]) pp = pp ^ (PW'(a_q) << j);
    end
    t = (TW'(acc_q) << D) ^ TW'(pp);
    // In reduced mode acc_q < x^M, so only bits M..M+D-1 can overflow the field.
    if (mode_q) begin
      for (int i = int'(M + D) - 1; i >= int'(M); i--) begin
        if (t[i]) t = t ^ (TW'(POLY) << (i - int'(M)));
      end
    end
    acc_d = mode_q ? AW'(t[M-1:0]) : AW'(t);
  end

  // Control FSM and datapath registers; y only updates on RUN -> DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= BW'(bus.b);
            mode_q     <= bus.mode;
            acc_q      <= '0;
            cnt_q      <= CW'(NDIG - 1);
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            y_q         <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_ks_mult_seq.sv
// Bench for gf2m_ks_mult_seq: four configurations (M=8/D=3, M=233/D=16,1,233).
module tb_gf2m_ks_mult_seq;

  localparam int W = 465;

  logic clk;
  logic rst_n;

  logic         in_valid_s [4];
  logic         mode_s     [4];
  logic         out_ready_s[4];
  logic [W-1:0] a_s        [4];
  logic [W-1:0] b_s        [4];
  logic         in_ready_s [4];
  logic         out_valid_s[4];
  logic [W-1:0] y_s        [4];

  int           ndig_tab[4];
  int           m_tab   [4];
  logic [W-1:0] poly_tab[4];

  int n_checks;
  int n_fail;

  gf2m_ks_mult_seq_if #(.M(8))   bus0 ();
  gf2m_ks_mult_seq_if #(.M(233)) bus1 ();
  gf2m_ks_mult_seq_if #(.M(233)) bus2 ();
  gf2m_ks_mult_seq_if #(.M(233)) bus3 ();

  gf2m_ks_mult_seq #(.M(8), .D(3), .POLY(9'h11B)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  gf2m_ks_mult_seq #(.M(233), .D(16))             dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  gf2m_ks_mult_seq #(.M(233), .D(1))              dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  gf2m_ks_mult_seq #(.M(233), .D(233))            dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  assign bus0.in_valid = in_valid_s[0];
  assign bus0.a        = a_s[0][7:0];
  assign bus0.b        = b_s[0][7:0];
  assign bus0.mode     = mode_s[0];
  assign bus0.out_ready = out_ready_s[0];
  assign in_ready_s[0]  = bus0.in_ready;
  assign out_valid_s[0] = bus0.out_valid;
  assign y_s[0]         = W'(bus0.y);

  assign bus1.in_valid = in_valid_s[1];
  assign bus1.a        = a_s[1][232:0];
  assign bus1.b        = b_s[1][232:0];
  assign bus1.mode     = mode_s[1];
  assign bus1.out_ready = out_ready_s[1];
  assign in_ready_s[1]  = bus1.in_ready;
  assign out_valid_s[1] = bus1.out_valid;
  assign y_s[1]         = W'(bus1.y);

  assign bus2.in_valid = in_valid_s[2];
  assign bus2.a        = a_s[2][232:0];
  assign bus2.b        = b_s[2][232:0];
  assign bus2.mode     = mode_s[2];
  assign bus2.out_ready = out_ready_s[2];
  assign in_ready_s[2]  = bus2.in_ready;
  assign out_valid_s[2] = bus2.out_valid;
  assign y_s[2]         = W'(bus2.y);

  assign bus3.in_valid = in_valid_s[3];
  assign bus3.a        = a_s[3][232:0];
  assign bus3.b        = b_s[3][232:0];
  assign bus3.mode     = mode_s[3];
  assign bus3.out_ready = out_ready_s[3];
  assign in_ready_s[3]  = bus3.in_ready;
  assign out_valid_s[3] = bus3.out_valid;
  assign y_s[3]         = W'(bus3.y);

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Textbook carry-less product, then polynomial long division by poly.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input int m, input logic [W-1:0] poly,
                                           input logic md);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < m; i++) if (b[i]) p = p ^ (a << i);
    if (md) begin
      for (int i = 2 * m - 2; i >= m; i--) if (p[i]) p = p ^ (poly << (i - m));
    end
    return p;
  endfunction

  function automatic logic [W-1:0] rand_op(input int m);
    logic [W-1:0] r;
    logic [W-1:0] one;
    one = W'(1);
    r = '0;
    for (int i = 0; i < 15; i++) r[32*i +: 32] = $urandom;
    return r & ((one << m) - one);
  endfunction

  // Full transaction: accept, measure latency, check result, release.
  task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic md, input logic [W-1:0] exp, input string tag);
    int lat;
    logic got;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = in_ready_s[k];
    end
    if (!got) begin
      chk({tag, "_rdy_timeout"}, W'(0), W'(1));
      return;
    end
    in_valid_s[k] = 1'b1;
    a_s[k] = a;
    b_s[k] = b;
    mode_s[k] = md;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[k] = 1'b0;
    a_s[k] = rand_op(m_tab[k]);
    b_s[k] = rand_op(m_tab[k]);
    mode_s[k] = ~md;
    lat = 0;
    got = 1'b0;
    while (!got && lat < ndig_tab[k] + 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = out_valid_s[k];
    end
    chk({tag, "_lat"}, W'(lat), W'(ndig_tab[k]));
    chk({tag, "_y"}, y_s[k], exp);
    out_ready_s[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_s[k] = 1'b0;
  endtask

  initial begin
    logic [W-1:0] one;
    logic [W-1:0] p233;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rm;
    int           cnt_tab[4];

    one  = W'(1);
    p233 = (one << 233) | (one << 74) | one;
    ndig_tab = '{3, 15, 233, 1};
    m_tab    = '{8, 233, 233, 233};
    poly_tab = '{W'(9'h11B), p233, p233, p233};
    cnt_tab  = '{50, 400, 120, 480};
    n_checks = 0;
    n_fail   = 0;

    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_s[k]  = 1'b0;
      mode_s[k]      = 1'b0;
      out_ready_s[k] = 1'b0;
      a_s[k]         = '0;
      b_s[k]         = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", W'(in_ready_s[0]), W'(0));
    chk("rst_out_valid", W'(out_valid_s[0]), W'(0));
    chk("rst_y", y_s[1], W'(0));
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk("post_rst_in_ready", W'(in_ready_s[k]), W'(1));

    // Directed small-field cases
    run_op(0, W'(8'h57), W'(8'h83), 1'b0, W'(16'h2B79), "m8_raw");
    run_op(0, W'(8'h57), W'(8'h83), 1'b1, W'(16'h00C1), "m8_red");
    run_op(0, W'(8'h01), W'(8'hFF), 1'b1, W'(16'h00FF), "m8_red_one");

    // Directed default-field cases
    run_op(1, one << 232, W'(2), 1'b0, one << 233, "m233_raw");
    run_op(1, one << 232, W'(2), 1'b1, (one << 74) | one, "m233_red");
    run_op(1, W'(0), rand_op(233), 1'b0, W'(0), "m233_zero");
    run_op(3, one << 232, W'(2), 1'b1, (one << 74) | one, "d233_red");
    run_op(2, one << 232, W'(2), 1'b0, one << 233, "d1_raw");

    // Backpressure: hold DONE with garbage on the input side
    @(negedge clk);
    chk("bp_in_ready", W'(in_ready_s[0]), W'(1));
    in_valid_s[0] = 1'b1;
    a_s[0] = W'(8'h57);
    b_s[0] = W'(8'h83);
    mode_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_out_valid", W'(out_valid_s[0]), W'(1));
    for (int c = 0; c < 10; c++) begin
      in_valid_s[0] = ~in_valid_s[0];
      a_s[0] = rand_op(8);
      b_s[0] = rand_op(8);
      @(posedge clk);
      @(negedge clk);
      chk("bp_y_stable", y_s[0], W'(16'h2B79));
      chk("bp_flags", W'({in_ready_s[0], out_valid_s[0]}), W'(2'b01));
    end
    in_valid_s[0] = 1'b0;
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_s[0] = 1'b0;
    chk("bp_release", W'({in_ready_s[0], out_valid_s[0]}), W'(2'b10));
    run_op(0, W'(8'hA5), W'(8'h3C), 1'b1,
           ref_mul(W'(8'hA5), W'(8'h3C), 8, W'(9'h11B), 1'b1), "b2b");

    // Reset mid-RUN: result must vanish at once
    @(negedge clk);
    in_valid_s[0] = 1'b1;
    a_s[0] = W'(8'hFF);
    b_s[0] = W'(8'hFF);
    mode_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", W'({in_ready_s[0], out_valid_s[0]}), W'(2'b00));
    chk("midrst_y", y_s[0], W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(0, W'(8'h03), W'(8'h03), 1'b0, W'(16'h0005), "post_midrst");

    // Random regression against the reference model
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < cnt_tab[k]; n++) begin
        ra = rand_op(m_tab[k]);
        rb = ($urandom_range(0, 31) == 0) ? W'(0) : rand_op(m_tab[k]);
        rm = 1'($urandom_range(0, 1));
        run_op(k, ra, rb, rm, ref_mul(ra, rb, m_tab[k], poly_tab[k], rm), "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
